// File: rtl/tmr_lane_monitor.sv
// TMR lane monitor: registered bitwise-majority voter over three lanes
// with per-lane mismatch tracking and graceful TMR/DMR/SIMPLEX/DEAD decay.
module tmr_lane_monitor #(
    parameter int W         = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic         clr_fail,
    output logic [W-1:0] Y,
    output logic         out_valid,
    output logic [2:0]   disagree,
    output logic [2:0]   lane_fail,
    output logic [1:0]   mode,
    output logic         no_majority
);

    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

    logic [W-1:0] lane [3];
    logic [2:0]   healthy;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic         have_p;
    logic [W-1:0] y_n;
    logic         nm_n;
    logic [2:0]   dis_n;
    logic [3:0]   cnt   [3];
    logic [3:0]   cnt_n [3];
    logic [2:0]   fail_n;

    assign lane[0] = A;
    assign lane[1] = B;
    assign lane[2] = C;
    assign healthy = ~lane_fail;

    // Mode follows directly from how many lanes are retired.
    assign mode = {1'b0, lane_fail[0]} + {1'b0, lane_fail[1]}
                + {1'b0, lane_fail[2]};

    // P is the lowest-index healthy lane, Q the next healthy one.
    always_comb begin
        p      = '0;
        q      = '0;
        have_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (healthy[i]) begin
                if (!have_p) begin
                    p      = lane[i];
                    have_p = 1'b1;
                end else begin
                    q = lane[i];
                end
            end
        end
    end

    // Vote according to the mode in effect at the start of the cycle.
    always_comb begin
        y_n  = Y;
        nm_n = 1'b0;
        case (mode)
            2'd0: y_n = (A & B) | (B & C) | (A & C);
            2'd1: begin
                y_n  = p;
                nm_n = (p != q);
            end
            2'd2: begin
                y_n  = p;
                nm_n = 1'b1;
            end
            default: begin
                y_n  = Y;
                nm_n = 1'b1;
            end
        endcase
        for (int i = 0; i < 3; i++) begin
            dis_n[i] = healthy[i] && (lane[i] != y_n);
        end
    end

    // Consecutive-mismatch counters; a lane retires when its count hits the limit.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_n[i]  = cnt[i];
            fail_n[i] = lane_fail[i];
            if (in_valid && healthy[i]) begin
                if (dis_n[i]) begin
                    if (cnt[i] != LIMIT) begin
                        cnt_n[i] = cnt[i] + 4'd1;
                    end
                    if (cnt_n[i] == LIMIT) begin
                        fail_n[i] = 1'b1;
                    end
                end else begin
                    cnt_n[i] = '0;
                end
            end
        end
    end

    // Output and health state registers; clear beats any count or fail set.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y           <= '0;
            out_valid   <= 1'b0;
            disagree    <= '0;
            no_majority <= 1'b0;
            lane_fail   <= '0;
            cnt         <= '{default: '0};
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y           <= y_n;
                disagree    <= dis_n;
                no_majority <= nm_n;
            end
            if (clr_fail) begin
                lane_fail <= '0;
                cnt       <= '{default: '0};
            end else begin
                lane_fail <= fail_n;
                cnt       <= cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_tmr_lane_monitor.sv
// Directed bench for tmr_lane_monitor: W=1 truth table plus W=8
// fault, degradation, clear and reset sequences.
module tb_tmr_lane_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       v1, a1, b1, c1, clr1;
    logic       y1, ov1, nm1;
    logic [2:0] dis1, lf1;
    logic [1:0] md1;

    logic       v, clr;
    logic [7:0] a, b, c, y;
    logic       ov, nm;
    logic [2:0] dis, lf;
    logic [1:0] md;

    int errors = 0;
    int checks = 0;

    logic [7:0] maj_tab = 8'b1110_1000;
    logic [2:0] dis_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd1, 3'd2, 3'd4, 3'd0};

    tmr_lane_monitor #(.W(1), .ERR_LIMIT(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1),
        .A(a1), .B(b1), .C(c1), .clr_fail(clr1),
        .Y(y1), .out_valid(ov1), .disagree(dis1),
        .lane_fail(lf1), .mode(md1), .no_majority(nm1)
    );

    tmr_lane_monitor #(.W(8), .ERR_LIMIT(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(v),
        .A(a), .B(b), .C(c), .clr_fail(clr),
        .Y(y), .out_valid(ov), .disagree(dis),
        .lane_fail(lf), .mode(md), .no_majority(nm)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vv, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] cc,
                        input logic cl);
        v = vv; a = aa; b = bb; c = cc; clr = cl;
        @(posedge clk);
        #1;
        v = 1'b0;
        clr = 1'b0;
    endtask

    task automatic out8(input string tag, input logic [7:0] ey,
                        input logic eov, input logic [2:0] ed,
                        input logic enm, input logic [2:0] elf,
                        input logic [1:0] em);
        chk({tag, "_y"}, 32'(y), 32'(ey));
        chk({tag, "_ov"}, 32'(ov), 32'(eov));
        chk({tag, "_dis"}, 32'(dis), 32'(ed));
        chk({tag, "_nm"}, 32'(nm), 32'(enm));
        chk({tag, "_lf"}, 32'(lf), 32'(elf));
        chk({tag, "_mode"}, 32'(md), 32'(em));
    endtask

    initial begin
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; c1 = 0; clr1 = 0;
        v = 0; a = 0; b = 0; c = 0; clr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        out8("rst", 8'h00, 1'b0, 3'b000, 1'b0, 3'b000, 2'd0);
        chk("rst1_y", 32'(y1), 32'd0);
        chk("rst1_ov", 32'(ov1), 32'd0);

        // W=1 truth table, one sample per cycle
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            v1 = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("tt%0d_y", i), 32'(y1), 32'(maj_tab[i]));
            chk($sformatf("tt%0d_dis", i), 32'(dis1), 32'(dis_tab[i]));
            chk($sformatf("tt%0d_ov", i), 32'(ov1), 32'd1);
            chk($sformatf("tt%0d_mode", i), 32'(md1), 32'd0);
        end
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("tt_idle_ov", 32'(ov1), 32'd0);
        chk("tt_idle_y", 32'(y1), 32'd1);

        // persistent fault on C
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        out8("pf1", 8'h5A, 1, 3'b100, 0, 3'b000, 2'd0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        out8("pf2", 8'h5A, 1, 3'b100, 0, 3'b000, 2'd0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        out8("pf3", 8'h5A, 1, 3'b100, 0, 3'b000, 2'd0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        out8("pf4", 8'h5A, 1, 3'b100, 0, 3'b100, 2'd1);
        step(1, 8'h5A, 8'h5A, 8'h00, 0);
        out8("pf_dmr", 8'h5A, 1, 3'b000, 0, 3'b100, 2'd1);
        step(0, 8'h99, 8'h98, 8'h97, 0);
        out8("hold", 8'h5A, 0, 3'b000, 0, 3'b100, 2'd1);

        // clear without a sample
        step(0, 8'h00, 8'h00, 8'h00, 1);
        out8("clr", 8'h5A, 0, 3'b000, 0, 3'b000, 2'd0);

        // intermittent fault on C: 3 miss, 1 match, 3 miss
        step(1, 8'h10, 8'h10, 8'h01, 0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        out8("im3", 8'h10, 1, 3'b100, 0, 3'b000, 2'd0);
        step(1, 8'h10, 8'h10, 8'h10, 0);
        out8("im_match", 8'h10, 1, 3'b000, 0, 3'b000, 2'd0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        out8("im6", 8'h10, 1, 3'b100, 0, 3'b000, 2'd0);
        step(1, 8'h10, 8'h10, 8'h01, 0);
        out8("im_fail", 8'h10, 1, 3'b100, 0, 3'b100, 2'd1);

        // degradation DMR -> SIMPLEX
        step(1, 8'h11, 8'h22, 8'h00, 0);
        out8("dg1", 8'h11, 1, 3'b010, 1, 3'b100, 2'd1);
        step(1, 8'h11, 8'h22, 8'h00, 0);
        step(1, 8'h11, 8'h22, 8'h00, 0);
        out8("dg3", 8'h11, 1, 3'b010, 1, 3'b100, 2'd1);
        step(1, 8'h11, 8'h22, 8'h00, 0);
        out8("dg4", 8'h11, 1, 3'b010, 1, 3'b110, 2'd2);
        step(1, 8'h33, 8'h44, 8'h55, 0);
        out8("sx", 8'h33, 1, 3'b000, 1, 3'b110, 2'd2);
        step(1, 8'h55, 8'h66, 8'h77, 1);
        out8("sx_clr", 8'h55, 1, 3'b000, 1, 3'b000, 2'd0);
        step(1, 8'h01, 8'h01, 8'h02, 0);
        out8("tmr_back", 8'h01, 1, 3'b100, 0, 3'b000, 2'd0);

        // all three lanes disagree with the vote -> TMR jumps to DEAD
        step(0, 8'h00, 8'h00, 8'h00, 1);
        step(1, 8'h01, 8'h02, 8'h04, 0);
        step(1, 8'h01, 8'h02, 8'h04, 0);
        step(1, 8'h01, 8'h02, 8'h04, 0);
        out8("dd3", 8'h00, 1, 3'b111, 0, 3'b000, 2'd0);
        step(1, 8'h01, 8'h02, 8'h04, 0);
        out8("dd4", 8'h00, 1, 3'b111, 0, 3'b111, 2'd3);
        step(1, 8'hFF, 8'hFF, 8'hFF, 0);
        out8("dead", 8'h00, 1, 3'b000, 1, 3'b111, 2'd3);

        // reset mid-operation with a sample in flight
        step(0, 8'h00, 8'h00, 8'h00, 1);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        step(1, 8'h5A, 8'h00, 8'h00, 0);
        out8("pre_rst", 8'h5A, 1, 3'b010, 1, 3'b100, 2'd1);
        rst = 1'b1;
        step(1, 8'h77, 8'h77, 8'h77, 0);
        rst = 1'b0;
        out8("mid_rst", 8'h00, 0, 3'b000, 0, 3'b000, 2'd0);
        step(1, 8'h5A, 8'h5A, 8'hFF, 0);
        out8("post_rst", 8'h5A, 1, 3'b100, 0, 3'b000, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
